// File: rtl/vga_bus_ctrl.sv
// rtl/vga_bus_ctrl.sv - bus-side controller for the VGA frame buffer write port
//
// Memory-mapped register bank (9 bytes at BASE_ADDR) on the 8-bit processor
// bus, driving frame buffer port A with single-pixel writes (optional X/Y
// auto-increment), a rectangle-fill engine and a full-screen clear engine.
//
// Ports:
//   CLK            system clock
//   RESET          synchronous, active-high reset
//   BUS_DATA       processor data bus, driven only the cycle after a read of this block
//   BUS_ADDR       processor address
//   BUS_WE         processor write strobe
//   FB_ADDR        frame buffer port-A address, {y,x}
//   FB_DATA        frame buffer port-A write data
//   FB_WE          frame buffer port-A write enable
//   CONFIG_COLOURS {COLOUR_HI,COLOUR_LO} to the signal generator
//   BUSY           fill or clear engine active
//   IRQ            one-cycle pulse when a fill or clear completes or is aborted

module vga_bus_ctrl #(
  parameter logic [7:0]  BASE_ADDR  = 8'hB0,
  parameter int          X_BITS     = 8,
  parameter int          Y_BITS     = 7,
  parameter int          PIX_BITS   = 1,
  parameter logic [15:0] COLOUR_RST = 16'hFF00
) (
  input  logic                     CLK,
  input  logic                     RESET,
  inout  wire  [7:0]               BUS_DATA,
  input  logic [7:0]               BUS_ADDR,
  input  logic                     BUS_WE,
  output logic [Y_BITS+X_BITS-1:0] FB_ADDR,
  output logic [PIX_BITS-1:0]      FB_DATA,
  output logic                     FB_WE,
  output logic [15:0]              CONFIG_COLOURS,
  output logic                     BUSY,
  output logic                     IRQ
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Bus decode. The subtraction wraps, so addresses below BASE_ADDR land
  // far above offset 8 and are rejected by the range test.
  logic [7:0] offset;
  logic [3:0] off;
  logic       in_range;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] wdata;

  assign offset   = BUS_ADDR - BASE_ADDR;
  assign off      = offset[3:0];
  assign in_range = (offset <= 8'd8);
  assign bus_wr   = BUS_WE && in_range;
  assign bus_rd   = !BUS_WE && in_range;
  assign wdata    = BUS_DATA;

  logic wr_x, wr_y, wr_pix, wr_ctrl, wr_w, wr_h, wr_clo, wr_chi;

  assign wr_x    = bus_wr && (off == 4'd0);
  assign wr_y    = bus_wr && (off == 4'd1);
  assign wr_pix  = bus_wr && (off == 4'd2);
  assign wr_ctrl = bus_wr && (off == 4'd3);
  assign wr_w    = bus_wr && (off == 4'd4);
  assign wr_h    = bus_wr && (off == 4'd5);
  assign wr_clo  = bus_wr && (off == 4'd6);
  assign wr_chi  = bus_wr && (off == 4'd7);

  // Register bank
  logic [X_BITS-1:0]   x_reg;
  logic [Y_BITS-1:0]   y_reg;
  logic [PIX_BITS-1:0] pix_reg;
  logic                auto_inc;
  logic [7:0]          w_reg;
  logic [7:0]          h_reg;
  logic [7:0]          colour_lo;
  logic [7:0]          colour_hi;
  logic                done;

  // Engine state: fb_x/fb_y are the coordinates currently on FB_ADDR
  logic [X_BITS-1:0]   fb_x;
  logic [Y_BITS-1:0]   fb_y;
  logic [X_BITS-1:0]   x0;
  logic [7:0]          w_lat;
  logic [7:0]          h_lat;
  logic [7:0]          col;
  logic [7:0]          row;

  // Read path
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [7:0] rd_mux;

  logic idle;
  logic pix_wr;
  logic abort_req;
  logic fill_last;
  logic clear_last;
  logic go_fill;
  logic go_clear;
  logic step;
  logic finish;

  assign idle       = (state == S_IDLE);
  assign pix_wr     = idle && wr_pix;
  assign abort_req  = wr_ctrl && wdata[3];
  assign fill_last  = (col == w_lat - 8'd1) && (row == h_lat - 8'd1);
  assign clear_last = &{fb_y, fb_x};

  assign BUSY           = !idle;
  assign FB_ADDR        = {fb_y, fb_x};
  assign CONFIG_COLOURS = {colour_hi, colour_lo};
  assign BUS_DATA       = rd_valid ? rd_data : 8'bz;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and engine control strobes. CLEAR takes priority over FILL
  // when both start bits arrive together; a zero-area fill never leaves IDLE.
  always_comb begin
    state_next = state;
    go_fill    = 1'b0;
    go_clear   = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_ctrl && wdata[2]) begin
          state_next = S_CLEAR;
          go_clear   = 1'b1;
        end else if (wr_ctrl && wdata[1] && (w_reg != 8'd0) && (h_reg != 8'd0)) begin
          state_next = S_FILL;
          go_fill    = 1'b1;
        end
      end
      S_FILL: begin
        if (abort_req || fill_last) begin
          state_next = S_IDLE;
          finish     = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      S_CLEAR: begin
        if (abort_req || clear_last) begin
          state_next = S_IDLE;
          finish     = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_mux = 8'h00;
    case (off)
      4'd0: rd_mux[X_BITS-1:0]   = x_reg;
      4'd1: rd_mux[Y_BITS-1:0]   = y_reg;
      4'd2: rd_mux[PIX_BITS-1:0] = pix_reg;
      4'd3: rd_mux[0]            = auto_inc;
      4'd4: rd_mux               = w_reg;
      4'd5: rd_mux               = h_reg;
      4'd6: rd_mux               = colour_lo;
      4'd7: rd_mux               = colour_hi;
      4'd8: rd_mux[1:0]          = {done, BUSY};
      default: rd_mux            = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_reg     <= '0;
      y_reg     <= '0;
      pix_reg   <= '0;
      auto_inc  <= 1'b0;
      w_reg     <= 8'd0;
      h_reg     <= 8'd0;
      colour_lo <= COLOUR_RST[7:0];
      colour_hi <= COLOUR_RST[15:8];
      done      <= 1'b0;
      fb_x      <= '0;
      fb_y      <= '0;
      x0        <= '0;
      w_lat     <= 8'd0;
      h_lat     <= 8'd0;
      col       <= 8'd0;
      row       <= 8'd0;
      FB_DATA   <= '0;
      FB_WE     <= 1'b0;
      IRQ       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      IRQ      <= finish;
      FB_WE    <= go_fill || go_clear || step || pix_wr;
      rd_valid <= bus_rd;
      rd_data  <= rd_mux;

      // Geometry and pixel registers are frozen while an engine runs
      if (idle && wr_x) begin
        x_reg <= wdata[X_BITS-1:0];
      end else if (pix_wr && auto_inc) begin
        x_reg <= x_reg + 1'b1;
      end

      if (idle && wr_y) begin
        y_reg <= wdata[Y_BITS-1:0];
      end else if (pix_wr && auto_inc && (&x_reg)) begin
        y_reg <= y_reg + 1'b1;
      end

      if (pix_wr) begin
        pix_reg <= wdata[PIX_BITS-1:0];
      end
      if (idle && wr_ctrl) begin
        auto_inc <= wdata[0];
      end
      if (idle && wr_w) begin
        w_reg <= wdata;
      end
      if (idle && wr_h) begin
        h_reg <= wdata;
      end
      if (wr_clo) begin
        colour_lo <= wdata;
      end
      if (wr_chi) begin
        colour_hi <= wdata;
      end

      // Completion outranks a coincident STATUS read so the event is not lost
      if (finish) begin
        done <= 1'b1;
      end else if (go_fill || go_clear) begin
        done <= 1'b0;
      end else if (bus_rd && (off == 4'd8)) begin
        done <= 1'b0;
      end

      if (pix_wr) begin
        fb_x    <= x_reg;
        fb_y    <= y_reg;
        FB_DATA <= wdata[PIX_BITS-1:0];
      end

      if (go_fill) begin
        fb_x    <= x_reg;
        fb_y    <= y_reg;
        FB_DATA <= pix_reg;
        x0      <= x_reg;
        w_lat   <= w_reg;
        h_lat   <= h_reg;
        col     <= 8'd0;
        row     <= 8'd0;
      end

      if (go_clear) begin
        fb_x    <= '0;
        fb_y    <= '0;
        FB_DATA <= pix_reg;
      end

      // Advance to the next pixel; coordinates wrap naturally at their width
      if (step) begin
        if (state == S_CLEAR) begin
          {fb_y, fb_x} <= {fb_y, fb_x} + 1'b1;
        end else if (col == w_lat - 8'd1) begin
          col  <= 8'd0;
          row  <= row + 8'd1;
          fb_x <= x0;
          fb_y <= fb_y + 1'b1;
        end else begin
          col  <= col + 8'd1;
          fb_x <= fb_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_bus_ctrl.sv
// tb/tb_vga_bus_ctrl.sv - scoreboard testbench for vga_bus_ctrl
module tb_vga_bus_ctrl;

  localparam int XB = 8;
  localparam int YB = 7;
  localparam int PB = 3;
  localparam int AB = XB + YB;
  localparam logic [7:0]  BASE = 8'hB0;
  localparam logic [15:0] CRST = 16'hFF00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  wire  [7:0]    bus_data;
  logic [7:0]    bus_addr = 8'h00;
  logic          bus_we = 1'b0;
  logic          drv_en = 1'b0;
  logic [7:0]    drv_val = 8'h00;
  logic [AB-1:0] fb_addr;
  logic [PB-1:0] fb_data;
  logic          fb_we;
  logic [15:0]   config_colours;
  logic          busy;
  logic          irq;

  assign bus_data = drv_en ? drv_val : 8'bz;

  vga_bus_ctrl #(
    .BASE_ADDR(BASE), .X_BITS(XB), .Y_BITS(YB), .PIX_BITS(PB), .COLOUR_RST(CRST)
  ) dut (
    .CLK(clk), .RESET(reset), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .FB_ADDR(fb_addr), .FB_DATA(fb_data), .FB_WE(fb_we), .CONFIG_COLOURS(config_colours),
    .BUSY(busy), .IRQ(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int val;
    int aux;
  } ev_t;

  ev_t fb_q[$];
  ev_t rd_q[$];
  ev_t col_q[$];
  int  irq_q[$];

  // Reference model: architectural register values plus the window of
  // cycles during which an engine owns the port
  int m_x, m_y, m_pix, m_auto, m_w, m_h, m_clo, m_chi;
  bit m_done;
  int m_done_at;
  int busy_start = -1;
  int busy_end = -1;
  bit mon_en = 1'b0;

  function automatic bit m_busy(input int j);
    return (j > busy_start) && (j <= busy_end);
  endfunction

  function automatic bit m_done_now(input int j);
    return m_done && (j >= m_done_at);
  endfunction

  function automatic int m_reg(input int off, input int j);
    case (off)
      0: return m_x;
      1: return m_y;
      2: return m_pix;
      3: return m_auto;
      4: return m_w;
      5: return m_h;
      6: return m_clo;
      7: return m_chi;
      default: return (int'(m_done_now(j)) << 1) | int'(m_busy(j));
    endcase
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_pix = 0; m_auto = 0; m_w = 0; m_h = 0;
    m_clo = int'(CRST[7:0]);
    m_chi = int'(CRST[15:8]);
    m_done = 1'b0;
    m_done_at = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input int off, input int val);
    int j;
    int n;
    bit b;
    j = cyc;
    b = m_busy(j);
    bus_addr = BASE + 8'(off);
    bus_we = 1'b1;
    drv_val = 8'(val);
    drv_en = 1'b1;
    case (off)
      0: if (!b) m_x = val % (1 << XB);
      1: if (!b) m_y = val % (1 << YB);
      2: if (!b) begin
        m_pix = val % (1 << PB);
        fb_q.push_back('{j + 1, (m_y << XB) | m_x, m_pix});
        if (m_auto != 0) begin
          m_x = (m_x + 1) % (1 << XB);
          if (m_x == 0) m_y = (m_y + 1) % (1 << YB);
        end
      end
      3: begin
        if (b) begin
          if (val[3]) begin
            while (fb_q.size() > 0 && fb_q[$].cyc > j) void'(fb_q.pop_back());
            while (irq_q.size() > 0 && irq_q[$] > j) void'(irq_q.pop_back());
            irq_q.push_back(j + 1);
            busy_end = j;
            m_done_at = j + 1;
          end
        end else begin
          m_auto = val & 1;
          n = 0;
          if (val[2]) begin
            n = 1 << AB;
            for (int i = 0; i < n; i++) fb_q.push_back('{j + 1 + i, i, m_pix});
          end else if (val[1] && m_w != 0 && m_h != 0) begin
            n = m_w * m_h;
            for (int r = 0; r < m_h; r++)
              for (int c = 0; c < m_w; c++)
                fb_q.push_back('{j + 1 + r * m_w + c,
                                 (((m_y + r) % (1 << YB)) << XB) | ((m_x + c) % (1 << XB)),
                                 m_pix});
          end
          if (n > 0) begin
            busy_start = j;
            busy_end = j + n;
            irq_q.push_back(j + n + 1);
            m_done = 1'b1;
            m_done_at = j + n + 1;
          end
        end
      end
      4: if (!b) m_w = val;
      5: if (!b) m_h = val;
      6: begin
        m_clo = val;
        col_q.push_back('{j + 1, (m_chi << 8) | m_clo, 0});
      end
      7: begin
        m_chi = val;
        col_q.push_back('{j + 1, (m_chi << 8) | m_clo, 0});
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    bus_we = 1'b0;
    drv_en = 1'b0;
    bus_addr = 8'h00;
  endtask

  // Reads take two cycles so the bench never drives while the DUT answers
  task automatic bus_rd(input int off);
    int j;
    j = cyc;
    rd_q.push_back('{j + 1, m_reg(off, j), 0});
    if (off == 8 && m_done_now(j)) m_done = 1'b0;
    bus_addr = BASE + 8'(off);
    bus_we = 1'b0;
    drv_en = 1'b0;
    @(posedge clk);
    #1;
    bus_addr = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int j;
    j = cyc;
    reset = 1'b1;
    while (fb_q.size() > 0 && fb_q[$].cyc > j) void'(fb_q.pop_back());
    while (irq_q.size() > 0 && irq_q[$] > j) void'(irq_q.pop_back());
    while (rd_q.size() > 0 && rd_q[$].cyc > j) void'(rd_q.pop_back());
    while (col_q.size() > 0 && col_q[$].cyc > j) void'(col_q.pop_back());
    col_q.push_back('{j + 1, int'(CRST), 0});
    if (busy_end > j) busy_end = j;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every DUT output against the scoreboard each cycle
  always @(negedge clk) begin
    bit exp_we;
    bit exp_irq;
    if (mon_en) begin
      exp_we = (fb_q.size() > 0) && (fb_q[0].cyc == cyc);
      chk("fb_we", int'(fb_we), int'(exp_we));
      if (exp_we) begin
        if (fb_we) begin
          chk("fb_addr", int'(fb_addr), fb_q[0].val);
          chk("fb_data", int'(fb_data), fb_q[0].aux);
        end
        void'(fb_q.pop_front());
      end
      exp_irq = (irq_q.size() > 0) && (irq_q[0] == cyc);
      chk("irq", int'(irq), int'(exp_irq));
      if (exp_irq) void'(irq_q.pop_front());
      chk("busy", int'(busy), int'(m_busy(cyc)));
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        chk("bus_data", int'(bus_data), rd_q[0].val);
        void'(rd_q.pop_front());
      end
      if (col_q.size() > 0 && col_q[0].cyc == cyc) begin
        chk("config_colours", int'(config_colours), col_q[0].val);
        void'(col_q.pop_front());
      end
    end
  end

  initial begin
    int x, y, w, h;
    model_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    mon_en = 1'b1;
    chk("colour_rst", int'(config_colours), int'(CRST));

    for (int i = 0; i <= 8; i++) bus_rd(i);

    // Single write, no auto-increment
    bus_wr(0, 10); bus_wr(1, 5); bus_wr(2, 1);
    bus_rd(0); bus_rd(1);

    // Auto-increment across the X wrap
    bus_wr(3, 1); bus_wr(0, 255); bus_wr(1, 3);
    bus_wr(2, 1); bus_wr(2, 1);
    bus_rd(0); bus_rd(1);

    // Rectangle fill and DONE clearing by STATUS read
    bus_wr(3, 0);
    bus_wr(0, 10); bus_wr(1, 5); bus_wr(4, 3); bus_wr(5, 2); bus_wr(2, 1);
    bus_wr(3, 2);
    tick(8);
    bus_rd(8); bus_rd(8);

    bus_wr(6, 8'h3C); bus_wr(7, 8'hA5);
    bus_rd(6); bus_rd(7);

    // Fill wrapping at both coordinate edges
    bus_wr(0, 253); bus_wr(1, 126); bus_wr(4, 5); bus_wr(5, 3); bus_wr(2, 6);
    bus_wr(3, 2);
    tick(17);
    bus_rd(8);

    // Randomised fills with colour and geometry writes while busy
    repeat (8) begin
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 127);
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      bus_wr(0, x); bus_wr(1, y); bus_wr(4, w); bus_wr(5, h);
      bus_wr(2, $urandom_range(0, 255));
      bus_wr(3, 2 | $urandom_range(0, 1));
      bus_wr(6, $urandom_range(0, 255));
      bus_wr(0, $urandom_range(0, 255));
      tick(w * h + 1);
      bus_rd(8);
    end

    // Random register traffic
    repeat (40) begin
      case ($urandom_range(0, 5))
        0: bus_wr(0, $urandom_range(0, 255));
        1: bus_wr(1, $urandom_range(0, 255));
        2: bus_wr(2, $urandom_range(0, 255));
        3: bus_wr(3, $urandom_range(0, 1));
        4: bus_wr(6 + $urandom_range(0, 1), $urandom_range(0, 255));
        default: bus_rd($urandom_range(0, 8));
      endcase
    end

    // Clear wins over fill, then zero-width fill is a no-op
    bus_wr(3, 0);
    bus_wr(2, 5);
    bus_wr(3, 6);
    tick((1 << AB) + 2);
    bus_wr(4, 0);
    bus_wr(3, 2);
    tick(4);
    bus_rd(8); bus_rd(8);

    // Abort on the 4th write cycle, pixel write while busy ignored
    bus_wr(0, 40); bus_wr(1, 20); bus_wr(4, 8); bus_wr(5, 8); bus_wr(2, 3);
    bus_wr(3, 2);
    bus_wr(2, 7);
    tick(2);
    bus_wr(3, 8);
    tick(3);
    bus_rd(8); bus_rd(2);

    // Reset during a clear
    bus_wr(3, 4);
    tick(4);
    do_reset();
    tick(3);
    bus_rd(0); bus_rd(7); bus_rd(8);
    tick(2);

    chk("fb_queue_drained", fb_q.size(), 0);
    chk("irq_queue_drained", irq_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
